// File: rtl/imem_pkg.sv
// Shared constants for the instruction-memory controller: NOP encoding,
// arbitration state encoding and word-address helpers.
package imem_pkg;

    // RV32I canonical NOP (addi x0, x0, 0), returned on illegal fetches
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    // Default instruction memory size in bytes
    localparam int unsigned DEPTH_BYTES_DEFAULT = 32;

    // Byte-offset bits dropped to form a word address
    localparam int unsigned WORD_OFS = 2;

    // Arbitration state: records which requester was granted last
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ARB_IDLE  = 2'd0;
    localparam arb_state_t ARB_FETCH = 2'd1;
    localparam arb_state_t ARB_LOAD  = 2'd2;

    // Width of a word address derived from a byte address width
    function automatic int unsigned word_aw(input int unsigned aw);
        return aw - WORD_OFS;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester arbiter (fetch vs loader) with a last-grant register.
// Round-robin on conflict, or loader-always-wins when fixed_pri_i is set.
module rr_arb2
    import imem_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_f_i,
    input  logic req_l_i,
    input  logic fixed_pri_i,
    output logic gnt_f_o,
    output logic gnt_l_o
);

    arb_state_t state_q, state_d;

    // Grant decision: a lone requester always wins; on conflict the
    // requester not granted last wins (IDLE counts as fetch-preferred)
    always_comb begin
        gnt_f_o = 1'b0;
        gnt_l_o = 1'b0;
        if (req_f_i && req_l_i) begin
            if (fixed_pri_i || (state_q == ARB_FETCH)) begin
                gnt_l_o = 1'b1;
            end else begin
                gnt_f_o = 1'b1;
            end
        end else begin
            gnt_f_o = req_f_i;
            gnt_l_o = req_l_i;
        end
    end

    // Next state follows the grant; no request keeps the pointer
    always_comb begin
        state_d = state_q;
        if (gnt_f_o) begin
            state_d = ARB_FETCH;
        end else if (gnt_l_o) begin
            state_d = ARB_LOAD;
        end
    end

    // Last-grant register, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/imem_ctrl.sv
// Instruction-memory controller: arbitrates the single memory port between
// CPU fetch (reads) and the PS program loader (writes), checks address
// legality and returns fetched words one cycle after acceptance.
// Optional feature macro: IMEM_BOOT_HOLD_EN (fetch held off until load_done).
module imem_ctrl
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES   = DEPTH_BYTES_DEFAULT,
    parameter int unsigned AW            = 32,
    parameter int unsigned RR_EN_DEFAULT = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    f_valid,
    output logic                    f_ready,
    input  logic [AW-1:0]           f_addr,
    output logic                    f_rvalid,
    output logic [31:0]             f_rdata,
    output logic                    f_err,
    input  logic                    l_valid,
    output logic                    l_ready,
    input  logic [AW-1:0]           l_addr,
    input  logic [31:0]             l_wdata,
    input  logic [3:0]              l_wstrb,
    output logic                    l_err,
    input  logic                    load_done,
    output logic                    boot_done,
    output logic                    mem_en,
    output logic [3:0]              mem_we,
    output logic [word_aw(AW)-1:0]  mem_addr,
    output logic [31:0]             mem_wdata,
    input  logic [31:0]             mem_rdata
);

    localparam logic [AW-1:0] DEPTH_LIM = AW'(DEPTH_BYTES);

    logic f_req, l_req;
    logic gnt_f, gnt_l;
    logic f_legal, l_legal;
    logic rsp_valid_q, rsp_valid_d;
    logic rsp_err_q, rsp_err_d;
    logic l_err_q, l_err_d;

`ifdef IMEM_BOOT_HOLD_EN
    logic boot_done_q, boot_done_d;

    // Sticky boot flag: set by load_done, visible from the next cycle
    always_comb begin
        boot_done_d = boot_done_q | load_done;
    end

    // Boot flag register
    always_ff @(posedge clk) begin
        if (!reset) begin
            boot_done_q <= 1'b0;
        end else begin
            boot_done_q <= boot_done_d;
        end
    end

    assign boot_done = boot_done_q;
`else
    logic unused_load_done;
    assign unused_load_done = load_done;

    // Fetch is permitted whenever the block is out of reset
    assign boot_done = reset;
`endif

    // Requests are masked in reset; fetch also waits for boot_done
    assign f_req = f_valid & reset & boot_done;
    assign l_req = l_valid & reset;

    rr_arb2 u_arb (
        .clk         (clk),
        .reset       (reset),
        .req_f_i     (f_req),
        .req_l_i     (l_req),
        .fixed_pri_i (RR_EN_DEFAULT == 0),
        .gnt_f_o     (gnt_f),
        .gnt_l_o     (gnt_l)
    );

    assign f_ready = gnt_f;
    assign l_ready = gnt_l;

    // No address wrap: any byte address at or beyond the end is illegal
    assign f_legal = (f_addr[1:0] == 2'b00) && (f_addr < DEPTH_LIM);
    assign l_legal = (l_addr < DEPTH_LIM);

    // Memory port drive; illegal requests are accepted but never touch memory
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = f_addr[AW-1:WORD_OFS];
        mem_wdata = l_wdata;
        if (gnt_f) begin
            mem_en = f_legal;
        end else if (gnt_l) begin
            mem_en   = l_legal;
            mem_addr = l_addr[AW-1:WORD_OFS];
            if (l_legal) begin
                mem_we = l_wstrb;
            end
        end
    end

    // Response pipeline next state: fetch response and loader error pulse
    always_comb begin
        rsp_valid_d = gnt_f;
        rsp_err_d   = gnt_f & ~f_legal;
        l_err_d     = gnt_l & ~l_legal;
    end

    // Response pipeline registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            l_err_q     <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            l_err_q     <= l_err_d;
        end
    end

    // Responses are suppressed while reset is held so an in-flight fetch
    // interrupted by reset never reports
    assign f_rvalid = rsp_valid_q & reset;
    assign f_err    = rsp_err_q & reset;
    assign l_err    = l_err_q & reset;
    assign f_rdata  = (f_rvalid && !f_err) ? mem_rdata : NOP_INSTR;

endmodule
